// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the MIPS memory bridge: FSM state codes, MMIO offsets, word width.
package mem_bridge_pkg;

  localparam int WORD_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ACCESS  = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;

  localparam logic [3:0] OFF_COUNTER = 4'h0;
  localparam logic [3:0] OFF_LED     = 4'h4;

endpackage

// File: rtl/mmio_regs.sv
// MMIO register block: free-running cycle counter, byte-writable LED register, read mux.
module mmio_regs
  import mem_bridge_pkg::*;
#(
  parameter int LED_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [3:0]        off,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic [LED_W-1:0]  leds
);

  logic [WORD_W-1:0] count_q, count_d;
  logic [LED_W-1:0]  leds_q, leds_d;
  logic              unused_bits;

  assign unused_bits = ^{be[3:2], wdata[WORD_W-1:16]};

  // Only byte lanes 0 and 1 are writable; LED bits above 15 stay at reset value.
  always_comb begin
    count_d = count_q + 32'd1;
    leds_d  = leds_q;
    if (we && off == OFF_LED) begin
      for (int i = 0; i < LED_W; i++) begin
        if (i < 8 && be[0]) begin
          leds_d[i] = wdata[i];
        end else if (i >= 8 && i < 16 && be[1]) begin
          leds_d[i] = wdata[i];
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      OFF_COUNTER: rdata = count_q;
      OFF_LED: begin
        for (int i = 0; i < LED_W && i < WORD_W; i++) begin
          rdata[i] = leds_q[i];
        end
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      leds_q  <= '0;
    end else begin
      count_q <= count_d;
      leds_q  <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule

// File: rtl/mem_bridge.sv
// Arbitrates MIPS fetch and data requests onto one synchronous-read RAM port with
// configurable wait states, and serves a small MMIO window in a single cycle.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
  parameter int          LED_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic [31:0]           i_rdata,
  output logic                  i_valid,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [3:0]            d_be,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_valid,
  output logic                  stall,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [DEPTH_LOG2-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic [LED_W-1:0]      leds
);

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic              is_data_q, is_data_d;
  logic              is_store_q, is_store_d;
  logic              i_valid_q, i_valid_d;
  logic              d_valid_q, d_valid_d;
  logic [WORD_W-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_W-1:0] d_rdata_q, d_rdata_d;

  logic              i_pend, d_pend, mmio_hit, mmio_we;
  logic [WORD_W-1:0] mmio_rdata;
  logic              unused_addr;

  assign unused_addr = ^{i_addr[31:DEPTH_LOG2+2], i_addr[1:0]};

  // A request whose valid is showing this cycle is already complete, not pending.
  assign i_pend   = i_req & ~i_valid_q;
  assign d_pend   = d_req & ~d_valid_q;
  assign mmio_hit = (d_addr[31:4] == MMIO_BASE[31:4]);

  assign mem_addr  = d_pend ? d_addr[DEPTH_LOG2+1:2] : i_addr[DEPTH_LOG2+1:2];
  assign mem_wdata = d_wdata;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    is_data_d  = is_data_q;
    is_store_d = is_store_q;
    i_valid_d  = 1'b0;
    d_valid_d  = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_en     = 1'b0;
    mem_we     = 4'b0000;
    mmio_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (d_pend && mmio_hit) begin
          d_valid_d = 1'b1;
          mmio_we   = d_we;
          if (!d_we) begin
            d_rdata_d = mmio_rdata;
          end
        end else if (d_pend || i_pend) begin
          mem_en     = 1'b1;
          mem_we     = (d_pend && d_we) ? d_be : 4'b0000;
          is_data_d  = d_pend;
          is_store_d = d_pend && d_we;
          wait_d     = WAIT_INIT;
          state_d    = (WAIT_CYCLES == 0) ? ST_CAPTURE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (wait_q == 4'd0) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
        if (is_data_q) begin
          d_valid_d = 1'b1;
          if (!is_store_q) begin
            d_rdata_d = mem_rdata;
          end
        end else begin
          i_valid_d = 1'b1;
          i_rdata_d = mem_rdata;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      mem_en  = 1'b0;
      mem_we  = 4'b0000;
      mmio_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      is_data_q  <= 1'b0;
      is_store_q <= 1'b0;
      i_valid_q  <= 1'b0;
      d_valid_q  <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      is_data_q  <= is_data_d;
      is_store_q <= is_store_d;
      i_valid_q  <= i_valid_d;
      d_valid_q  <= d_valid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  mmio_regs #(
    .LED_W (LED_W)
  ) u_mmio (
    .clk   (clk),
    .rst   (rst),
    .we    (mmio_we),
    .be    (d_be),
    .off   (d_addr[3:0]),
    .wdata (d_wdata),
    .rdata (mmio_rdata),
    .leds  (leds)
  );

  assign i_valid = i_valid_q;
  assign d_valid = d_valid_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign stall   = ~rst & ((i_req & ~i_valid_q) | (d_req & ~d_valid_q));

endmodule
